// File: rtl/inst_prefetch_pkg.sv
// rtl/inst_prefetch_pkg.sv - shared types and default widths for the instruction prefetch queue
package inst_prefetch_pkg;

  localparam int IMSB_DEF  = 15;
  localparam int AMSB_DEF  = 14;
  localparam int DEPTH_DEF = 4;
  localparam int CMSB_DEF  = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [AMSB_DEF:0] addr;
    logic [IMSB_DEF:0] inst;
  } entry_t;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// rtl/inst_prefetch_fifo.sv - circular {addr,inst} buffer exposing its two oldest entries
module prefetch_fifo #(
  parameter int AMSB  = 14,
  parameter int IMSB  = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       flush,
  input  logic                       push,
  input  logic [AMSB:0]              push_addr,
  input  logic [IMSB:0]              push_inst,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [AMSB:0]              e0_addr,
  output logic [IMSB:0]              e0_inst,
  output logic [AMSB:0]              e1_addr,
  output logic [IMSB:0]              e1_inst
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AMSB:0] mem_addr [DEPTH];
  logic [IMSB:0] mem_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1;

  assign rd_ptr1 = rd_ptr + PW'(1);
  assign e0_addr = mem_addr[rd_ptr];
  assign e0_inst = mem_inst[rd_ptr];
  assign e1_addr = mem_addr[rd_ptr1];
  assign e1_inst = mem_inst[rd_ptr1];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch queue between ROM and cpu with redirect on miss
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int IMSB  = IMSB_DEF,
  parameter int AMSB  = AMSB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CMSB  = CMSB_DEF
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            setb,
  input  logic            req_pc,
  input  logic [AMSB:0]   pc,
  output logic            ack_inst,
  output logic [IMSB:0]   inst,
  output logic [AMSB:0]   rom_addr,
  output logic            rom_en,
  input  logic [IMSB:0]   rom_inst,
  output logic [CMSB:0]   miss_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = CW + 1;

  state_t        state;
  logic [AMSB:0] nf, rd_addr;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic [AMSB:0] f0_addr, f1_addr, e1_addr;
  logic [IMSB:0] f0_inst, f1_inst, e1_inst;
  logic          e1_valid, hit, adv, byp, redirect, flush, push, fetch_ok;
  logic [RW-1:0] resv;

  prefetch_fifo #(.AMSB(AMSB), .IMSB(IMSB), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstb(rstb), .flush(flush), .push(push),
    .push_addr(rd_addr), .push_inst(rom_inst), .pop(adv), .count(count),
    .e0_addr(f0_addr), .e0_inst(f0_inst), .e1_addr(f1_addr), .e1_inst(f1_inst)
  );

  // Data still on the ROM bus acts as the second entry when only one is queued.
  assign e1_valid = (count > CW'(1)) || (count == CW'(1) && rd_valid);
  assign e1_addr  = (count > CW'(1)) ? f1_addr : rd_addr;
  assign e1_inst  = (count > CW'(1)) ? f1_inst : rom_inst;

  always_comb begin
    hit      = 1'b0;
    adv      = 1'b0;
    byp      = 1'b0;
    redirect = 1'b0;
    if (setb && state == S_RUN && req_pc) begin
      if (count != '0) begin
        if (f0_addr == pc)                 hit = 1'b1;
        else if (e1_valid && e1_addr == pc) adv = 1'b1;
        else                                redirect = 1'b1;
      end else if (rd_valid && rd_addr == pc) begin
        byp = 1'b1;
      end else if (!((rom_en && rom_addr == pc) || nf == pc)) begin
        redirect = 1'b1;
      end
    end
  end

  assign ack_inst = hit | adv | byp;
  assign inst     = hit ? f0_inst : adv ? e1_inst : byp ? rom_inst : '0;
  assign flush    = redirect | ~setb;
  assign push     = rd_valid & ~flush;
  assign resv     = RW'(count) + RW'(push) - RW'(adv) + RW'(rom_en);
  assign fetch_ok = resv < RW'(DEPTH);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= S_IDLE;
      nf       <= '0;
      rom_addr <= '0;
      rom_en   <= 1'b0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      miss_cnt <= '0;
    end else begin
      rd_valid <= rom_en & ~flush;
      rd_addr  <= rom_addr;
      if (!setb) begin
        state  <= S_IDLE;
        rom_en <= 1'b0;
      end else if (state == S_IDLE || redirect) begin
        // Entering S_MISS always launches the fetch for pc on this edge.
        state    <= S_MISS;
        rom_en   <= 1'b1;
        rom_addr <= pc;
        nf       <= pc + 1'b1;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end else begin
        state  <= S_RUN;
        rom_en <= fetch_ok;
        if (fetch_ok) begin
          rom_addr <= nf;
          nf       <= nf + 1'b1;
        end
      end
    end
  end

endmodule
